// File: rtl/key_pkg.sv
// key_pkg: shared types and elaboration-time helpers for the key_debounce block.
//   key_state_t - per-channel debounce FSM state encoding.
//   ms_to_cycles - converts a clock frequency and a millisecond interval to a cycle count.
//   cnt_width   - counter width able to hold 0 .. n-1 (never narrower than 1 bit).
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Divide first so the intermediate product stays inside 32 bits for
  // realistic clock rates (50 MHz * 1000 ms would overflow the other way).
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // A counter that stops at n-1 needs $clog2(n) bits; a one-cycle interval
  // still needs a real (1-bit) register so the compare logic stays uniform.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-flop synchroniser, debounce FSM, optional long-press timer.
// Latency: press/release accepted 2 + 1 + DB_CYCLES cycles after the pin first samples the new level.
// Backpressure: none; all outputs are registered levels or single-cycle pulses.
//
// Ports:
//   sys_clk     - system clock
//   rst         - synchronous active-high reset
//   key_in      - raw key pin, active-low, asynchronous to sys_clk
//   key_level   - debounced state, 1 = pressed
//   key_press   - one-cycle pulse on an accepted press
//   key_release - one-cycle pulse on an accepted release
//   key_long    - one-cycle pulse once per press after LONG_CYCLES held
//
// Build option: KEY_LONG_PRESS_EN builds the long-press counter; otherwise key_long is tied to 0.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 20
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_CYCLES = 100
`endif
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned     DB_W    = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Synchroniser. Resets to 1 (released) so a reset never looks like a
  // press edge; a key held through reset is picked up via the normal path.
  // ---------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       ks;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign ks = ~sync_q[1];

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  key_state_t      state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_d;
  logic            press_d;
  logic            release_d;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    level_d   = key_level;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ks) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!ks) begin
          // Any release during the window is treated as bounce.
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          // Never reaches past DB_LAST, so the counter cannot wrap.
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!ks) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end

      RELEASE_WAIT: begin
        if (ks) begin
          // Release bounce: resume the press without any output change.
          state_d = PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Long-press timer. Runs only while PRESSED, so time spent rejecting a
  // release bounce pauses it rather than restarting it.
  // ---------------------------------------------------------------------
`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned       LONG_W    = cnt_width(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic              long_clear;
  logic              long_count;
  logic [LONG_W-1:0] long_cnt_q;
  logic              long_done_q;

  // A new accepted press restarts the timer; a return from RELEASE_WAIT does not.
  assign long_clear = (state_q == PRESS_WAIT) && (state_d == PRESSED);
  assign long_count = (state_q == PRESSED);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (long_clear) begin
        long_cnt_q  <= '0;
        long_done_q <= 1'b0;
      end else if (long_count && !long_done_q) begin
        if (long_cnt_q == LONG_LAST) begin
          // Counter parks at LONG_LAST; long_done blocks a second pulse.
          key_long    <= 1'b1;
          long_done_q <= 1'b1;
        end else begin
          long_cnt_q <= long_cnt_q + 1'b1;
        end
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: multi-channel active-low push-button conditioner (level + press/release/long pulses).
// Latency: press/release accepted 2 + 1 + DB_CYCLES cycles after the pin first samples the new level.
// Backpressure: none; every output is a registered level or single-cycle pulse per key.
//
// Ports:
//   sys_clk     - system clock (CLK_FREQ_HZ)
//   rst         - synchronous active-high reset
//   key_in      - [NUM_KEYS] raw key pins, active-low, asynchronous
//   key_level   - [NUM_KEYS] debounced state, 1 = pressed
//   key_press   - [NUM_KEYS] one-cycle pulse on an accepted press
//   key_release - [NUM_KEYS] one-cycle pulse on an accepted release
//   key_long    - [NUM_KEYS] one-cycle pulse once per press after LONG_MS held
//
// Build option: KEY_LONG_PRESS_EN enables the long-press timers; without it key_long is constant 0.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS    = 4,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);

  // A zero-cycle window would make the DB_LAST/LONG_LAST compares underflow.
  if (DB_CYCLES == 0 || LONG_CYCLES == 0) begin : g_bad_cfg
    $error("key_debounce: CLK_FREQ_HZ/DEBOUNCE_MS/LONG_MS give a zero-cycle interval");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES   (DB_CYCLES)
`ifdef KEY_LONG_PRESS_EN
      ,
      .LONG_CYCLES (LONG_CYCLES)
`endif
    ) u_ch (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce at 1 kHz, DB = 20, LONG = 100 cycles.
// Inputs are driven and outputs sampled on the falling edge; one edge-count helper
// also keeps per-key pulse tallies so whole windows can be checked for stray pulses.
module tb_key_debounce;

  localparam int NK = 4;

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  always #5 sys_clk = ~sys_clk;

  key_debounce #(
    .NUM_KEYS    (NK),
    .CLK_FREQ_HZ (1000),
    .DEBOUNCE_MS (20),
    .LONG_MS     (100)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  int n_chk = 0;
  int n_err = 0;

  int press_n [NK] = '{default: 0};
  int rel_n   [NK] = '{default: 0};
  int long_n  [NK] = '{default: 0};
  int lev_n   [NK] = '{default: 0};
  int clash_n      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling on each following falling edge.
  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      for (int k = 0; k < NK; k++) begin
        if (key_press[k])                  press_n[k]++;
        if (key_release[k])                rel_n[k]++;
        if (key_long[k])                   long_n[k]++;
        if (key_level[k])                  lev_n[k]++;
        if (key_press[k] && key_release[k]) clash_n++;
        if (key_press[k] && key_long[k])    clash_n++;
      end
    end
  endtask

  int s_press, s_rel, s_long, s_lev;
  logic [NK-1:0] long_exp2;
  logic [NK-1:0] long_exp3;

  initial begin
    long_exp2 = LONG_ON ? 4'b0100 : 4'b0000;
    long_exp3 = LONG_ON ? 4'b1000 : 4'b0000;

    // ---------------- reset ----------------
    rst    = 1'b1;
    key_in = 4'hF;
    tick(3);
    check("rst_level",   32'(key_level),   32'h0);
    check("rst_press",   32'(key_press),   32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_long",    32'(key_long),    32'h0);
    rst = 1'b0;
    tick(30);
    check("idle_level",  32'(key_level),   32'h0);
    check("idle_pulses", 32'(press_n[0] + press_n[1] + press_n[2] + press_n[3]), 32'h0);

    // ---------------- clean press / release on key0 ----------------
    s_long = long_n[0];
    key_in[0] = 1'b0;
    tick(22);
    check("t1_press_early", 32'(key_press), 32'h0);
    tick(1);
    check("t1_press",       32'(key_press), 32'h1);
    check("t1_level",       32'(key_level), 32'h1);
    tick(1);
    check("t1_press_1cyc",  32'(key_press), 32'h0);
    tick(26);
    key_in[0] = 1'b1;
    tick(22);
    check("t1_rel_early",   32'(key_release), 32'h0);
    check("t1_level_held",  32'(key_level),   32'h1);
    tick(1);
    check("t1_release",     32'(key_release), 32'h1);
    check("t1_level_low",   32'(key_level),   32'h0);
    tick(1);
    check("t1_rel_1cyc",    32'(key_release), 32'h0);
    check("t1_no_long",     32'(long_n[0] - s_long), 32'h0);

    // ---------------- bounce rejection on key1 ----------------
    s_press = press_n[1];
    s_rel   = rel_n[1];
    s_long  = long_n[1];
    s_lev   = lev_n[1];
    for (int i = 0; i < 12; i++) begin
      key_in[1] = i[0];
      tick(5);
    end
    key_in[1] = 1'b1;
    tick(40);
    check("t2_press", 32'(press_n[1] - s_press), 32'h0);
    check("t2_rel",   32'(rel_n[1] - s_rel),     32'h0);
    check("t2_long",  32'(long_n[1] - s_long),   32'h0);
    check("t2_level", 32'(lev_n[1] - s_lev),     32'h0);

    // ---------------- long press on key2 ----------------
    s_long = long_n[2];
    key_in[2] = 1'b0;
    tick(23);
    check("t3_press",      32'(key_press), 32'h4);
    tick(99);
    check("t3_long_early", 32'(key_long),  32'h0);
    tick(1);
    check("t3_long",       32'(key_long),  32'(long_exp2));
    tick(77);
    key_in[2] = 1'b1;
    tick(30);
    check("t3_long_once",  32'(long_n[2] - s_long), 32'(LONG_ON));
    check("t3_released",   32'(key_level), 32'h0);

    // ---------------- release bounce on key3 ----------------
    s_rel  = rel_n[3];
    s_long = long_n[3];
    key_in[3] = 1'b0;
    tick(23);
    check("t4_press",       32'(key_press), 32'h8);
    tick(5);
    key_in[3] = 1'b1;
    tick(10);
    check("t4_level_mid",   32'(key_level), 32'h8);
    key_in[3] = 1'b0;
    tick(94);
    check("t4_long_early",  32'(key_long),  32'h0);
    check("t4_level_kept",  32'(key_level), 32'h8);
    tick(1);
    check("t4_long_paused", 32'(key_long),  32'(long_exp3));
    check("t4_no_release",  32'(rel_n[3] - s_rel), 32'h0);
    key_in[3] = 1'b1;
    tick(30);
    check("t4_long_once",   32'(long_n[3] - s_long), 32'(LONG_ON));

    // ---------------- simultaneous keys 0 and 3 ----------------
    key_in = 4'b0110;
    tick(22);
    check("t5_press_early", 32'(key_press), 32'h0);
    tick(1);
    check("t5_press_both",  32'(key_press), 32'h9);
    tick(5);
    key_in = 4'hF;
    tick(30);
    check("t5_released",    32'(key_level), 32'h0);

    // ---------------- reset mid-press on key0 ----------------
    key_in[0] = 1'b0;
    tick(23);
    check("t6_press",       32'(key_press), 32'h1);
    tick(10);
    s_rel = rel_n[0];
    rst = 1'b1;
    tick(1);
    check("t6_rst_level",   32'(key_level),   32'h0);
    check("t6_rst_press",   32'(key_press),   32'h0);
    check("t6_rst_release", 32'(key_release), 32'h0);
    check("t6_rst_long",    32'(key_long),    32'h0);
    rst = 1'b0;
    tick(22);
    check("t6_repress_early", 32'(key_press), 32'h0);
    tick(1);
    check("t6_repress",     32'(key_press), 32'h1);
    check("t6_relevel",     32'(key_level), 32'h1);
    check("t6_no_release",  32'(rel_n[0] - s_rel), 32'h0);
    key_in[0] = 1'b1;
    tick(30);

    check("no_clash", 32'(clash_n), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
